// File: rtl/cpu_ctrl.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: owns PC, IR, accumulator,
// operand and address registers, and drives the ROM, RAM and ALU interfaces.
module cpu_ctrl #(
  parameter logic [7:0] RESET_PC      = 8'h00,
  parameter bit         ILLEGAL_HALTS = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rom_data,
  output logic [7:0] rom_addr,
  output logic       rom_rd,
  input  logic [7:0] ram_rdata,
  output logic [7:0] ram_addr,
  output logic       ram_rd,
  output logic       ram_wr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] alu_out,
  output logic [3:0] alu_op,
  output logic [7:0] alu_in,
  output logic [7:0] accum,
  output logic       alu_im_int,
  output logic       halted,
  output logic       illegal_op
);

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLdo = 4'h1;
  localparam logic [3:0] OpLda = 4'h2;
  localparam logic [3:0] OpSto = 4'h3;
  localparam logic [3:0] OpPre = 4'h4;
  localparam logic [3:0] OpAdd = 4'h5;
  localparam logic [3:0] OpLdm = 4'h6;
  localparam logic [3:0] OpAdn = 4'h7;
  localparam logic [3:0] OpInc = 4'h8;
  localparam logic [3:0] OpDec = 4'h9;
  localparam logic [3:0] OpJmp = 4'hA;
  localparam logic [3:0] OpClr = 4'hB;
  localparam logic [3:0] OpIlC = 4'hC;
  localparam logic [3:0] OpIlD = 4'hD;
  localparam logic [3:0] OpIlE = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StOper,
    StMem,
    StWb,
    StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] opnd_q, opnd_d;
  logic [7:0] addr_q, addr_d;
  logic       alu_im_q, alu_im_d;
  logic       illegal_q, illegal_d;

  logic [3:0] op;
  logic [3:0] imm;

  assign op  = ir_q[7:4];
  assign imm = ir_q[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      pc_q      <= RESET_PC;
      ir_q      <= 8'h00;
      acc_q     <= 8'h00;
      opnd_q    <= 8'h00;
      addr_q    <= 8'h00;
      alu_im_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      addr_q    <= addr_d;
      alu_im_q  <= alu_im_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    addr_d    = addr_q;
    alu_im_d  = 1'b0;
    illegal_d = illegal_q;
    rom_addr  = pc_q;
    rom_rd    = 1'b0;
    ram_rd    = 1'b0;
    ram_wr    = 1'b0;

    unique case (state_q)
      StFetch: begin
        rom_rd  = 1'b1;
        ir_d    = rom_data;
        pc_d    = pc_q + 8'd1;
        state_d = StDecode;
      end

      StDecode: begin
        case (op)
          OpLdo, OpLda, OpSto, OpPre, OpAdd, OpJmp: state_d = StOper;
          OpAdn, OpClr: begin
            // The immediate lands in opnd now so the strobe and ALU see it stable in WB.
            opnd_d   = {4'h0, imm};
            alu_im_d = 1'b1;
            state_d  = StWb;
          end
          OpInc, OpDec, OpLdm: state_d = StWb;
          OpHlt: state_d = StHalt;
          OpIlC, OpIlD, OpIlE: begin
            illegal_d = 1'b1;
            state_d   = ILLEGAL_HALTS ? StHalt : StFetch;
          end
          OpNop:   state_d = StFetch;
          default: state_d = StFetch;
        endcase
      end

      StOper: begin
        rom_rd = 1'b1;
        if (op == OpJmp) begin
          pc_d    = rom_data;
          state_d = StFetch;
        end else begin
          pc_d    = pc_q + 8'd1;
          addr_d  = rom_data;
          state_d = StMem;
        end
      end

      StMem: begin
        case (op)
          OpLdo: begin
            rom_addr = addr_q;
            rom_rd   = 1'b1;
            opnd_d   = rom_data;
            state_d  = StWb;
          end
          OpLda, OpAdd: begin
            ram_rd  = 1'b1;
            opnd_d  = ram_rdata;
            state_d = StWb;
          end
          OpPre: begin
            ram_rd  = 1'b1;
            opnd_d  = ram_rdata;
            state_d = StFetch;
          end
          OpSto: begin
            ram_wr  = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end

      StWb: begin
        acc_d   = alu_out;
        state_d = StFetch;
      end

      StHalt: state_d = StHalt;

      default: state_d = StFetch;
    endcase
  end

  assign halted     = (state_q == StHalt);
  assign alu_op     = halted ? OpHlt : op;
  assign alu_in     = opnd_q;
  assign accum      = acc_q;
  assign ram_addr   = addr_q;
  assign ram_wdata  = acc_q;
  assign alu_im_int = alu_im_q;
  assign illegal_op = illegal_q;

endmodule
